// File: rtl/alu_cmd_ctrl_pkg.sv
// ============================================================================
//  Module      : alu_cmd_ctrl_pkg
//  Description : Shared definitions for the ALU command controller: ALU
//                select codes, the MUL opcode and controller state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_cmd_ctrl_pkg;

    // 3-bit ALU select codes; the ALU decodes the same values.
    localparam logic [2:0] SEL_ADD  = 3'd0;
    localparam logic [2:0] SEL_SUB  = 3'd1;
    localparam logic [2:0] SEL_AND  = 3'd2;
    localparam logic [2:0] SEL_OR   = 3'd3;
    localparam logic [2:0] SEL_XOR  = 3'd4;
    localparam logic [2:0] SEL_SHL  = 3'd5;
    localparam logic [2:0] SEL_SHR  = 3'd6;
    localparam logic [2:0] SEL_PASS = 3'd7;

    // Command opcodes 0-7 map straight onto the ALU select codes.
    localparam logic [3:0] OP_MUL = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // True for opcodes that drive a single ALU operation.
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op[3] == 1'b0);
    endfunction

endpackage : alu_cmd_ctrl_pkg

`default_nettype wire

// File: rtl/alu_cmd_ctrl.sv
// ============================================================================
//  Module      : alu_cmd_ctrl
//  Description : Command-side initiator for an external combinational ALU.
//                Accepts commands over cmd valid/ready, drives the ALU from
//                registered operands, returns results over rsp valid/ready.
//                MUL is a WIDTH-cycle shift-and-add using the ALU's ADD.
//  Ports       : clk, rst                      - clock, sync active-high reset
//                cmd_valid/ready/op/a/b        - command channel
//                alu_a/alu_b/alu_sel           - registered ALU drive
//                alu_out/alu_carry             - ALU result
//                rsp_valid/ready/data/carry/err- response channel
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_cmd_ctrl
    import alu_cmd_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_carry,
    output logic             rsp_err
);

    localparam int              CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] mplier;
    logic             ovf;
    logic             mc_ovf;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             mul_last;
    logic             mul_ovf_step;

    assign accept       = cmd_valid && cmd_ready;
    assign mul_last     = (cnt == CNT_LAST);
    // An add step overflows if the adder carries or the multiplicand has
    // already lost bits off its top end.
    assign mul_ovf_step = mplier[0] & (alu_carry | mc_ovf);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (is_alu_op(cmd_op))    state_nxt = ST_EXEC;
                    else if (cmd_op == OP_MUL) state_nxt = ST_MUL;
                    else                       state_nxt = ST_RESP;
                end
            end
            ST_EXEC: state_nxt = ST_RESP;
            ST_MUL:  if (mul_last) state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        cmd_ready = (state == ST_IDLE);
        rsp_valid = (state == ST_RESP);
    end

    // ------------------------------------------------------------- datapath
    // During MUL, alu_a holds the accumulator and alu_b the shifting
    // multiplicand, so the ALU always sees acc + mcand.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= SEL_ADD;
            mplier    <= '0;
            ovf       <= 1'b0;
            mc_ovf    <= 1'b0;
            cnt       <= '0;
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_alu_op(cmd_op)) begin
                            alu_a   <= cmd_a;
                            alu_b   <= cmd_b;
                            alu_sel <= cmd_op[2:0];
                        end else if (cmd_op == OP_MUL) begin
                            alu_a   <= '0;
                            alu_b   <= cmd_a;
                            alu_sel <= SEL_ADD;
                            mplier  <= cmd_b;
                            ovf     <= 1'b0;
                            mc_ovf  <= 1'b0;
                            cnt     <= '0;
                        end else begin
                            rsp_data  <= '0;
                            rsp_carry <= 1'b0;
                            rsp_err   <= 1'b1;
                        end
                    end
                end
                ST_EXEC: begin
                    rsp_data  <= alu_out;
                    rsp_carry <= alu_carry;
                    rsp_err   <= 1'b0;
                end
                ST_MUL: begin
                    if (mplier[0]) begin
                        alu_a <= alu_out;
                    end
                    ovf    <= ovf | mul_ovf_step;
                    mc_ovf <= mc_ovf | alu_b[WIDTH-1];
                    alu_b  <= alu_b << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (mul_last) begin
                        rsp_data  <= mplier[0] ? alu_out : alu_a;
                        rsp_carry <= ovf | mul_ovf_step;
                        rsp_err   <= 1'b0;
                    end
                end
                default: ; // ST_RESP: response registers held until accepted
            endcase
        end
    end

endmodule : alu_cmd_ctrl

`default_nettype wire
